// File: rtl/ctrl_pkg.sv
// Shared types and constants for the microprogram sequencer:
// branch field encodings, next-address mux selects, FSM states.
package ctrl_pkg;

   localparam int ADDR_W = 16;

   typedef enum logic [2:0] {
      BT_NEXT = 3'd0,
      BT_JUMP = 3'd1,
      BT_MAP  = 3'd2,
      BT_JZ   = 3'd3,
      BT_JNZ  = 3'd4,
      BT_CALL = 3'd5,
      BT_RET  = 3'd6,
      BT_HALT = 3'd7
   } branch_t;

   typedef enum logic [1:0] {
      SEL_INC = 2'd0,
      SEL_JMP = 2'd1,
      SEL_MAP = 2'd2
   } sel_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/ctrl_addr_sequencer_if.sv
// Sequencer <-> control-unit bus: next-address mux loop, branch field,
// datapath flags and control-store/status outputs.
interface ctrl_addr_sequencer_if;
   import ctrl_pkg::*;

   logic [ADDR_W-1:0] reg_in;
   logic [2:0]        branch_type;
   logic              cond_z;
   logic              stall;
   logic [ADDR_W-1:0] car;
   logic [ADDR_W-1:0] inc_addr;
   logic [1:0]        select;
   logic              rom_en;
   logic              halted;
   logic              ret_err;

   // Sequencer side
   modport master (
      input  reg_in, branch_type, cond_z, stall,
      output car, inc_addr, select, rom_en, halted, ret_err
   );

   // Control-unit / datapath side
   modport slave (
      output reg_in, branch_type, cond_z, stall,
      input  car, inc_addr, select, rom_en, halted, ret_err
   );

endinterface

// File: rtl/ctrl_branch_decode.sv
// Combinational decode of the microinstruction sequencing field into the
// next-address mux select plus call/return/halt flags.
module ctrl_branch_decode
   import ctrl_pkg::*;
(
   input  logic [2:0] branch_type,
   input  logic       cond_z,
   output logic [1:0] select,
   output logic       is_call,
   output logic       is_ret,
   output logic       is_halt
);

   // Map branch field and zero flag to mux select and control flags
   always_comb begin
      select  = SEL_INC;
      is_call = 1'b0;
      is_ret  = 1'b0;
      is_halt = 1'b0;
      unique case (branch_t'(branch_type))
         BT_NEXT: select = SEL_INC;
         BT_JUMP: select = SEL_JMP;
         BT_MAP:  select = SEL_MAP;
         BT_JZ:   select = cond_z ? SEL_JMP : SEL_INC;
         BT_JNZ:  select = cond_z ? SEL_INC : SEL_JMP;
         BT_CALL: begin
            select  = SEL_JMP;
            is_call = 1'b1;
         end
         BT_RET:  begin
            select = SEL_INC;
            is_ret = 1'b1;
         end
         BT_HALT: begin
            select  = SEL_INC;
            is_halt = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_addr_sequencer.sv
// Control-address register and next-address sequencer. Each microinstruction
// spends one cycle in FETCH (control store read) and one or more in EXEC
// (held there while the datapath stalls). Supports a single-level return.
module ctrl_addr_sequencer #(
   parameter int                 ADDR_W     = ctrl_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   ctrl_addr_sequencer_if.master bus
);
   import ctrl_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] car_q, car_d;
   logic [ADDR_W-1:0] ret_reg_q, ret_reg_d;
   logic              ret_valid_q, ret_valid_d;
   logic              ret_err_q, ret_err_d;
   logic [ADDR_W-1:0] inc_addr;
   logic [1:0]        dec_sel;
   logic [1:0]        sel;
   logic              is_call, is_ret, is_halt;

   assign inc_addr = car_q + ADDR_W'(1);

   ctrl_branch_decode u_decode (
      .branch_type (bus.branch_type),
      .cond_z      (bus.cond_z),
      .select      (dec_sel),
      .is_call     (is_call),
      .is_ret      (is_ret),
      .is_halt     (is_halt)
   );

   // State and address registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         car_q       <= RESET_ADDR;
         ret_reg_q   <= '0;
         ret_valid_q <= 1'b0;
         ret_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         car_q       <= car_d;
         ret_reg_q   <= ret_reg_d;
         ret_valid_q <= ret_valid_d;
         ret_err_q   <= ret_err_d;
      end
   end

   // Next-state, CAR update and mux select
   always_comb begin
      state_d     = state_q;
      car_d       = car_q;
      ret_reg_d   = ret_reg_q;
      ret_valid_d = ret_valid_q;
      ret_err_d   = ret_err_q;
      sel         = SEL_INC;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            sel = dec_sel;
            if (!bus.stall) begin
               if (is_halt) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_FETCH;
                  if (is_ret) begin
                     // RET bypasses the external mux and reloads the saved address
                     if (ret_valid_q) begin
                        car_d       = ret_reg_q;
                        ret_valid_d = 1'b0;
                     end else begin
                        car_d     = RESET_ADDR;
                        ret_err_d = 1'b1;
                     end
                  end else begin
                     car_d = bus.reg_in;
                     if (is_call) begin
                        ret_reg_d   = inc_addr;
                        ret_valid_d = 1'b1;
                     end
                  end
               end
            end
         end
         S_HALT:  state_d = S_HALT;
      endcase
   end

   assign bus.car      = car_q;
   assign bus.inc_addr = inc_addr;
   assign bus.select   = sel;
   assign bus.rom_en   = (state_q == S_FETCH);
   assign bus.halted   = (state_q == S_HALT);
   assign bus.ret_err  = ret_err_q;

endmodule

// File: tb/tb_ctrl_addr_sequencer.sv
// Directed bench for ctrl_addr_sequencer. The bench models the external
// next-address mux (inc / jump / map) and checks each step against
// hand-computed values.
module tb_ctrl_addr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] jump_addr;
   logic [15:0] map_addr;
   int          n_assert = 0;
   int          n_fail   = 0;

   ctrl_addr_sequencer_if bus ();

   ctrl_addr_sequencer #(
      .ADDR_W     (16),
      .RESET_ADDR (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // External next-address mux model
   always_comb begin
      case (bus.select)
         2'd0:    bus.reg_in = bus.inc_addr;
         2'd1:    bus.reg_in = jump_addr;
         default: bus.reg_in = map_addr;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.branch_type = 3'd0;
      bus.cond_z = 1'b0;
      bus.stall = 1'b0;
      jump_addr = 16'h0000;
      map_addr = 16'h0000;
      tick();
      tick();
      chk("rst_car", bus.car, 16'h0000);
      chk("rst_rom_en", {15'b0, bus.rom_en}, 16'h0000);
      chk("rst_halted", {15'b0, bus.halted}, 16'h0000);
      chk("rst_ret_err", {15'b0, bus.ret_err}, 16'h0000);
      chk("rst_select", {14'b0, bus.select}, 16'h0000);

      // Release reset: one IDLE cycle, then FETCH
      rst = 1'b0;
      tick();
      chk("fetch0_rom_en", {15'b0, bus.rom_en}, 16'h0001);
      chk("fetch0_car", bus.car, 16'h0000);

      // Five NEXT words: car advances once every two cycles
      for (int unsigned i = 1; i <= 5; i++) begin
         tick();
         chk("next_exec_rom_en", {15'b0, bus.rom_en}, 16'h0000);
         chk("next_exec_car", bus.car, 16'(i - 1));
         tick();
         chk("next_fetch_car", bus.car, 16'(i));
         chk("next_fetch_rom_en", {15'b0, bus.rom_en}, 16'h0001);
      end

      // JZ not taken at car=5
      bus.branch_type = 3'd3; bus.cond_z = 1'b0; jump_addr = 16'h0020;
      tick();
      chk("jz0_select", {14'b0, bus.select}, 16'h0000);
      tick();
      chk("jz0_car", bus.car, 16'h0006);

      // JZ taken
      bus.cond_z = 1'b1;
      tick();
      chk("jz1_select", {14'b0, bus.select}, 16'h0001);
      tick();
      chk("jz1_car", bus.car, 16'h0020);

      // JNZ with cond_z=1 falls through
      bus.branch_type = 3'd4; jump_addr = 16'h0700;
      tick();
      chk("jnz1_select", {14'b0, bus.select}, 16'h0000);
      tick();
      chk("jnz1_car", bus.car, 16'h0021);

      // MAP
      bus.branch_type = 3'd2; bus.cond_z = 1'b0; map_addr = 16'h0010;
      tick();
      chk("map_select", {14'b0, bus.select}, 16'h0002);
      tick();
      chk("map_car", bus.car, 16'h0010);

      // CALL 0x10 -> 0x40, then RET -> 0x11
      bus.branch_type = 3'd5; jump_addr = 16'h0040;
      tick();
      chk("call_select", {14'b0, bus.select}, 16'h0001);
      tick();
      chk("call_car", bus.car, 16'h0040);
      bus.branch_type = 3'd6;
      tick();
      chk("ret_select", {14'b0, bus.select}, 16'h0000);
      tick();
      chk("ret_car", bus.car, 16'h0011);
      chk("ret_err_clear", {15'b0, bus.ret_err}, 16'h0000);

      // Second RET with no saved address
      tick();
      tick();
      chk("ret2_car", bus.car, 16'h0000);
      chk("ret2_err", {15'b0, bus.ret_err}, 16'h0001);

      // JUMP under three stalled EXEC cycles
      bus.branch_type = 3'd1; jump_addr = 16'h1234; bus.stall = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk("stall_car", bus.car, 16'h0000);
         chk("stall_select", {14'b0, bus.select}, 16'h0001);
         chk("stall_rom_en", {15'b0, bus.rom_en}, 16'h0000);
      end
      bus.stall = 1'b0;
      tick();
      chk("stall_release_car", bus.car, 16'h1234);

      // cond_z change during stall is honoured
      bus.branch_type = 3'd3; bus.cond_z = 1'b0; jump_addr = 16'h0100; bus.stall = 1'b1;
      tick();
      chk("jz_stall_sel0", {14'b0, bus.select}, 16'h0000);
      bus.cond_z = 1'b1;
      #1;
      chk("jz_stall_sel1", {14'b0, bus.select}, 16'h0001);
      bus.stall = 1'b0;
      tick();
      chk("jz_stall_car", bus.car, 16'h0100);

      // Wrap at 0xFFFF
      bus.branch_type = 3'd1; bus.cond_z = 1'b0; jump_addr = 16'hFFFF;
      tick();
      tick();
      chk("wrap_car_ffff", bus.car, 16'hFFFF);
      chk("wrap_inc_addr", bus.inc_addr, 16'h0000);
      bus.branch_type = 3'd0;
      tick();
      tick();
      chk("wrap_car_0", bus.car, 16'h0000);

      // NEXT to car=1, then HALT
      tick();
      tick();
      chk("pre_halt_car", bus.car, 16'h0001);
      bus.branch_type = 3'd7;
      tick();
      chk("halt_exec_select", {14'b0, bus.select}, 16'h0000);
      tick();
      chk("halt_halted", {15'b0, bus.halted}, 16'h0001);
      chk("halt_rom_en", {15'b0, bus.rom_en}, 16'h0000);
      chk("halt_car", bus.car, 16'h0001);
      bus.branch_type = 3'd1; jump_addr = 16'h0BAD;
      tick();
      tick();
      chk("halt_frozen_car", bus.car, 16'h0001);
      chk("halt_frozen_halted", {15'b0, bus.halted}, 16'h0001);
      chk("halt_ret_err_sticky", {15'b0, bus.ret_err}, 16'h0001);

      // Reset out of HALT
      rst = 1'b1;
      tick();
      chk("rst_halt_car", bus.car, 16'h0000);
      chk("rst_halt_halted", {15'b0, bus.halted}, 16'h0000);
      chk("rst_halt_ret_err", {15'b0, bus.ret_err}, 16'h0000);
      chk("rst_halt_rom_en", {15'b0, bus.rom_en}, 16'h0000);
      rst = 1'b0;
      tick();
      chk("rst_halt_fetch", {15'b0, bus.rom_en}, 16'h0001);

      // Set ret_err again, then reset in the middle of a stall
      bus.branch_type = 3'd6;
      tick();
      tick();
      chk("ret3_err", {15'b0, bus.ret_err}, 16'h0001);
      bus.branch_type = 3'd1; jump_addr = 16'h0055; bus.stall = 1'b1;
      tick();
      tick();
      chk("mid_stall_select", {14'b0, bus.select}, 16'h0001);
      rst = 1'b1;
      tick();
      chk("rst_stall_car", bus.car, 16'h0000);
      chk("rst_stall_ret_err", {15'b0, bus.ret_err}, 16'h0000);
      chk("rst_stall_select", {14'b0, bus.select}, 16'h0000);
      chk("rst_stall_rom_en", {15'b0, bus.rom_en}, 16'h0000);
      rst = 1'b0; bus.stall = 1'b0;
      tick();
      chk("post_rst_fetch", {15'b0, bus.rom_en}, 16'h0001);
      tick();
      tick();
      chk("post_rst_jump_car", bus.car, 16'h0055);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
